// File: rtl/config_pkg.sv
// Slice of the CVA6 derived configuration type: only the fields reported by cva6_cfg_info.
// Field names follow the upstream config_pkg so the real package can replace this one.
package config_pkg;

  typedef struct packed {
    logic [31:0] XLEN, VLEN, PLEN, GPLEN;
    logic        RVA, RVB, RVC, RVF, RVD, RVH, RVS, RVU, RVV;
    logic        RVZCB, RVZCMT, RVZCMP, RVZiCond, RVZicntr, RVZihpm, ZKN;
    logic        XF16, XF16ALT, XF8, XFVec;
    logic [31:0] NUM_THREADS, NrCommitPorts, NrIssuePorts, NrWbPorts, NrRgprPorts;
    logic [31:0] NR_SB_ENTRIES;
    logic [31:0] ICACHE_SET_ASSOC, ICACHE_INDEX_WIDTH, ICACHE_LINE_WIDTH;
    logic [31:0] DCACHE_SET_ASSOC, DCACHE_INDEX_WIDTH, DCACHE_LINE_WIDTH;
    logic [31:0] InstrTlbEntries, DataTlbEntries, SharedTlbDepth, NrPMPEntries;
    logic [31:0] RASDepth, BTBEntries, BHTEntries;
    logic [63:0] DmBaseAddress, HaltAddress, ExceptionAddress;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_info_pkg.sv
// Word map, field packing and CRC-32 helpers for the configuration-discovery unit.
// Optional CRC word is enabled by defining CVA6_CFG_INFO_CRC_EN.
package cfg_info_pkg;
  import config_pkg::*;

  localparam logic [31:0] MAGIC = 32'h43564136;

  localparam int unsigned W_MAGIC   = 0;
  localparam int unsigned W_VERSION = 1;
  localparam int unsigned W_WIDTHS  = 2;
  localparam int unsigned W_ISA     = 3;
  localparam int unsigned W_PIPE    = 4;
  localparam int unsigned W_ICACHE  = 5;
  localparam int unsigned W_DCACHE  = 6;
  localparam int unsigned W_MMU     = 7;
  localparam int unsigned W_BPRED   = 8;
  localparam int unsigned W_DM_BASE = 9;
  localparam int unsigned W_HALT    = 10;
  localparam int unsigned W_EXC     = 11;
  localparam int unsigned W_CRC     = 12;

`ifdef CVA6_CFG_INFO_CRC_EN
  localparam int unsigned NUM_WORDS = 13;
`else
  localparam int unsigned NUM_WORDS = 12;
`endif

  // The map is padded to the full 4-bit index space; unused slots read as zero.
  localparam int unsigned MAP_DEPTH = 16;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [0:0] {StIdle, StStream} dump_state_e;

  typedef logic [MAP_DEPTH-1:0][31:0] info_map_t;

  function automatic logic [31:0] sat_field(logic [31:0] val, int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (val > max_val) ? max_val : val;
  endfunction

  function automatic logic [31:0] pack4x8(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                          logic [31:0] d);
    return (sat_field(a, 8) << 24) | (sat_field(b, 8) << 16) | (sat_field(c, 8) << 8) |
           sat_field(d, 8);
  endfunction

  function automatic logic [31:0] pack_cache(logic [31:0] assoc, logic [31:0] idx_w,
                                             logic [31:0] line_w);
    return (sat_field(assoc, 8) << 24) | (sat_field(idx_w, 8) << 16) | sat_field(line_w, 16);
  endfunction

  // Words 0..11; the CRC word depends on all of these and is built separately.
  function automatic logic [31:0] pack_word(cva6_cfg_t cfg, logic [15:0] version,
                                            int unsigned idx);
    logic [31:0] w;
    logic [19:0] isa;
    isa = {cfg.XFVec, cfg.XF8, cfg.XF16ALT, cfg.XF16, cfg.ZKN, cfg.RVZihpm, cfg.RVZicntr,
           cfg.RVZiCond, cfg.RVZCMP, cfg.RVZCMT, cfg.RVZCB, cfg.RVV, cfg.RVU, cfg.RVS,
           cfg.RVH, cfg.RVD, cfg.RVF, cfg.RVC, cfg.RVB, cfg.RVA};
    w = '0;
    case (idx)
      W_MAGIC:   w = MAGIC;
      W_VERSION: w = {version, 8'(NUM_WORDS), 8'h00};
      W_WIDTHS:  w = pack4x8(cfg.XLEN, cfg.VLEN, cfg.PLEN, cfg.GPLEN);
      W_ISA:     w = {12'h000, isa};
      W_PIPE:    w = (sat_field(cfg.NUM_THREADS, 8) << 24) |
                     (sat_field(cfg.NrCommitPorts, 4) << 20) |
                     (sat_field(cfg.NrIssuePorts, 4) << 16) |
                     (sat_field(cfg.NrWbPorts, 4) << 12) |
                     (sat_field(cfg.NrRgprPorts, 4) << 8) |
                     sat_field(cfg.NR_SB_ENTRIES, 8);
      W_ICACHE:  w = pack_cache(cfg.ICACHE_SET_ASSOC, cfg.ICACHE_INDEX_WIDTH,
                                cfg.ICACHE_LINE_WIDTH);
      W_DCACHE:  w = pack_cache(cfg.DCACHE_SET_ASSOC, cfg.DCACHE_INDEX_WIDTH,
                                cfg.DCACHE_LINE_WIDTH);
      W_MMU:     w = pack4x8(cfg.InstrTlbEntries, cfg.DataTlbEntries, cfg.SharedTlbDepth,
                             cfg.NrPMPEntries);
      W_BPRED:   w = (sat_field(cfg.RASDepth, 8) << 24) | (sat_field(cfg.BTBEntries, 8) << 16) |
                     sat_field(cfg.BHTEntries, 16);
      W_DM_BASE: w = cfg.DmBaseAddress[31:0];
      W_HALT:    w = cfg.HaltAddress[31:0];
      W_EXC:     w = cfg.ExceptionAddress[31:0];
      default:   w = '0;
    endcase
    return w;
  endfunction

  // Reflected CRC-32 step over one word, bytes taken LSB first.
  function automatic logic [31:0] crc32_update(logic [31:0] crc, logic [31:0] word);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) begin
      c = c ^ {24'h0, word[8*b +: 8]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] map_crc(cva6_cfg_t cfg, logic [15:0] version);
    logic [31:0] c;
    c = CRC_INIT;
    for (int unsigned i = 0; i < W_CRC; i++) begin
      c = crc32_update(c, pack_word(cfg, version, i));
    end
    return ~c;
  endfunction

  function automatic info_map_t build_map(cva6_cfg_t cfg, logic [15:0] version);
    info_map_t m;
    m = '0;
    for (int unsigned i = 0; i < W_CRC; i++) begin
      m[i] = pack_word(cfg, version, i);
    end
`ifdef CVA6_CFG_INFO_CRC_EN
    m[W_CRC] = map_crc(cfg, version);
`endif
    return m;
  endfunction

endpackage

// File: rtl/cva6_cfg_info_if.sv
// Read-port and dump-port signals of cva6_cfg_info; suffixes are from the unit's point of view.
interface cva6_cfg_info_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        dump_start_i;
  logic        dump_busy_o;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [31:0] dump_data_o;
  logic        dump_last_o;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, dump_start_i, dump_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  dump_busy_o, dump_valid_o, dump_data_o, dump_last_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, dump_start_i, dump_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output dump_busy_o, dump_valid_o, dump_data_o, dump_last_o
  );
endinterface

// File: rtl/cva6_cfg_info_crc32.sv
// Running CRC-32 over dumped words, one word per cycle; built only with CVA6_CFG_INFO_CRC_EN.
`ifdef CVA6_CFG_INFO_CRC_EN
module cfg_info_crc32
  import cfg_info_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        update_i,
  input  logic [31:0] word_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (update_i) begin
      crc_d = crc32_update(crc_q, word_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = ~crc_q;

endmodule
`endif

// File: rtl/cva6_cfg_info.sv
// Read-only configuration map: random-access read port plus streaming dump port.
// Define CVA6_CFG_INFO_CRC_EN to append a CRC-32 word to the map.
module cva6_cfg_info
  import cfg_info_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
  parameter logic [15:0]           InfoVersion = 16'h0001
) (
  input logic            clk_i,
  input logic            rst_i,
  cva6_cfg_info_if.slave bus
);

  localparam info_map_t Map     = build_map(CVA6Cfg, InfoVersion);
  localparam logic [3:0] LastIdx = 4'(NUM_WORDS - 1);

  // Read port: single response register.
  logic        req_ready;
  logic        req_accept;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  assign req_ready  = !rsp_valid_q || bus.rsp_ready_i;
  assign req_accept = bus.req_valid_i && req_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (req_accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = Map[bus.req_addr_i];
      rsp_err_d   = 32'(bus.req_addr_i) >= NUM_WORDS;
    end else if (bus.rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;

  // Dump port: independent of the read port.
  dump_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        streaming;
  logic        dump_hs;
  logic [31:0] dump_word;

  assign streaming = (state_q == StStream);
  assign dump_hs   = streaming && bus.dump_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dump_start_i) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (dump_hs) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CVA6_CFG_INFO_CRC_EN
  logic        crc_clear;
  logic        crc_update;
  logic [31:0] crc_value;

  // A new dump restarts the running CRC so it never carries state across streams.
  assign crc_clear  = (state_q == StIdle) && bus.dump_start_i;
  assign crc_update = dump_hs && (32'(idx_q) < W_CRC);

  cfg_info_crc32 u_crc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (crc_clear),
    .update_i (crc_update),
    .word_i   (dump_word),
    .crc_o    (crc_value)
  );

  always_comb begin
    dump_word = Map[idx_q];
    if (32'(idx_q) == W_CRC) begin
      dump_word = crc_value;
    end
  end
`else
  always_comb begin
    dump_word = Map[idx_q];
  end
`endif

  assign bus.dump_busy_o  = streaming;
  assign bus.dump_valid_o = streaming;
  assign bus.dump_data_o  = streaming ? dump_word : '0;
  assign bus.dump_last_o  = streaming && (idx_q == LastIdx);

endmodule

// File: tb/tb_cva6_cfg_info.sv
// Self-checking bench for cva6_cfg_info: table-driven reads, dump sequences, scoreboard queues.
module tb_cva6_cfg_info;
  import config_pkg::*;

`ifdef CVA6_CFG_INFO_CRC_EN
  localparam int NW = 13;
`else
  localparam int NW = 12;
`endif

  function automatic cva6_cfg_t make_cfg();
    cva6_cfg_t c;
    c = '0;
    c.XLEN = 32'd64;  c.VLEN = 32'd300;  c.PLEN = 32'd56;  c.GPLEN = 32'd58;
    c.RVA = 1'b1;  c.RVC = 1'b1;  c.RVF = 1'b1;  c.RVD = 1'b1;  c.RVS = 1'b1;  c.RVU = 1'b1;
    c.RVZCB = 1'b1;  c.RVZiCond = 1'b1;  c.RVZicntr = 1'b1;  c.RVZihpm = 1'b1;  c.XFVec = 1'b1;
    c.NUM_THREADS = 32'd1;  c.NrCommitPorts = 32'd2;  c.NrIssuePorts = 32'd1;
    c.NrWbPorts = 32'd20;  c.NrRgprPorts = 32'd3;  c.NR_SB_ENTRIES = 32'd8;
    c.ICACHE_SET_ASSOC = 32'd4;  c.ICACHE_INDEX_WIDTH = 32'd12;  c.ICACHE_LINE_WIDTH = 32'd128;
    c.DCACHE_SET_ASSOC = 32'd8;  c.DCACHE_INDEX_WIDTH = 32'd12;  c.DCACHE_LINE_WIDTH = 32'd70000;
    c.InstrTlbEntries = 32'd16;  c.DataTlbEntries = 32'd16;  c.SharedTlbDepth = 32'd64;
    c.NrPMPEntries = 32'd300;
    c.RASDepth = 32'd2;  c.BTBEntries = 32'd32;  c.BHTEntries = 32'd128;
    c.DmBaseAddress = 64'h1_0000_0800;
    c.HaltAddress = 64'h8000_0000;
    c.ExceptionAddress = 64'h808;
    return c;
  endfunction

  localparam cva6_cfg_t TbCfg = make_cfg();

  // Hand-derived words for TbCfg (saturated fields: VLEN, NrWbPorts, DCACHE line, NrPMPEntries).
  localparam logic [31:0] EXP_BASE [12] = '{
    32'h43564136, {16'h00A5, 8'(NW), 8'h00}, 32'h40FF383A, 32'h000872DD,
    32'h0121F308, 32'h040C0080, 32'h080CFFFF, 32'h101040FF,
    32'h02200080, 32'h00000800, 32'h80000000, 32'h00000808
  };

  typedef struct packed {logic [31:0] data; logic err;} rd_exp_t;
  typedef struct packed {logic [31:0] data; logic last;} dump_exp_t;
  typedef struct {logic [3:0] addr; logic [31:0] exp_data; logic exp_err;} rd_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rd_exp_t   rd_q[$];
  dump_exp_t dump_q[$];

  always #5 clk = ~clk;

  cva6_cfg_info_if bus ();

  cva6_cfg_info #(
    .CVA6Cfg     (TbCfg),
    .InfoVersion (16'h00A5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Bit-serial CRC-32 (reflected) over the bytes of w0..w11, LSB byte first.
  function automatic logic [31:0] tb_crc();
    logic [31:0] c;
    logic [7:0]  byte_v;
    c = 32'hFFFFFFFF;
    for (int w = 0; w < 12; w++) begin
      for (int b = 0; b < 4; b++) begin
        byte_v = 8'(EXP_BASE[w] >> (8 * b));
        for (int k = 0; k < 8; k++) begin
          if (c[0] ^ byte_v[k]) c = (c >> 1) ^ 32'hEDB88320;
          else                  c = c >> 1;
        end
      end
    end
    return ~c;
  endfunction

  function automatic logic [31:0] exp_word(int idx);
    if (idx < 12) return EXP_BASE[idx];
    if (idx == 12 && NW == 13) return tb_crc();
    return 32'h0;
  endfunction

  function automatic rd_exp_t exp_rd(int idx);
    rd_exp_t e;
    e.data = exp_word(idx);
    e.err  = (idx >= NW);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, required completion", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [3:0] addr, input logic [31:0] ed, input logic ee);
    int n;
    n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) fail_now("req_accept_timeout");
    else rd_q.push_back('{ed, ee});
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic dump_start();
    if (!bus.dump_busy_o) begin
      for (int i = 0; i < NW; i++) dump_q.push_back('{exp_word(i), (i == NW - 1)});
    end
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
  endtask

  task automatic wait_dump_idle(input int limit, input string name);
    int n;
    n = 0;
    while (bus.dump_busy_o && n < limit) begin
      tick();
      n++;
    end
    if (bus.dump_busy_o) fail_now(name);
  endtask

  // Scoreboard: compare every response / dump handshake against the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      rd_q.delete();
      dump_q.delete();
    end else begin
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (rd_q.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_data_o, 32'h0);
          chk("rsp_unexpected_count", 32'd1, 32'd0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rsp_data", bus.rsp_data_o, e.data);
          chk("rsp_err", 32'(bus.rsp_err_o), 32'(e.err));
        end
      end
      if (bus.dump_valid_o && bus.dump_ready_i) begin
        if (dump_q.size() == 0) begin
          chk("dump_unexpected", bus.dump_data_o, 32'hFFFF_FFFF);
        end else begin
          dump_exp_t d;
          d = dump_q.pop_front();
          chk("dump_data", bus.dump_data_o, d.data);
          chk("dump_last", 32'(bus.dump_last_o), 32'(d.last));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t vecs [16];
    for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), exp_word(i), (i >= NW)};

    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.rsp_ready_i  = 1'b0;
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_data", bus.rsp_data_o, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_dump_busy", 32'(bus.dump_busy_o), 32'd0);
    chk("rst_dump_valid", 32'(bus.dump_valid_o), 32'd0);
    chk("rst_dump_data", bus.dump_data_o, 32'h0);
    chk("rst_dump_last", 32'(bus.dump_last_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single read of index 0, one-cycle latency.
    bus.rsp_ready_i = 1'b1;
    rd_issue(4'd0, exp_word(0), 1'b0);
    chk("rd0_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("rd0_data", bus.rsp_data_o, 32'h43564136);
    chk("rd0_err", 32'(bus.rsp_err_o), 32'd0);
    tick();

    // Back-to-back reads across the whole index space.
    for (int i = 0; i < 16; i++) begin
      rd_issue(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
      chk("rd_ready_high", 32'(bus.req_ready_o), 32'd1);
    end
    chk("rd15_err", 32'(bus.rsp_err_o), 32'd1);
    chk("rd15_data", bus.rsp_data_o, 32'h0);
    tick();

    // Response backpressure: hold, check stability, release with a request waiting.
    bus.rsp_ready_i = 1'b0;
    rd_issue(4'd3, exp_word(3), 1'b0);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 4'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(bus.req_ready_o), 32'd0);
      chk("bp_data_stable", bus.rsp_data_o, exp_word(3));
      chk("bp_valid_held", 32'(bus.rsp_valid_o), 32'd1);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", 32'(bus.req_ready_o), 32'd1);
    rd_q.push_back(exp_rd(5));
    tick();
    bus.req_valid_i = 1'b0;
    tick();

    // Dump with ready tied high.
    bus.dump_ready_i = 1'b1;
    dump_start();
    chk("dump_busy_n1", 32'(bus.dump_busy_o), 32'd1);
    chk("dump_first_word", bus.dump_data_o, 32'h43564136);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      chk("dump_valid_consec", 32'(bus.dump_valid_o), 32'd1);
      chk("dump_last_pos", 32'(bus.dump_last_o), 32'(i == NW - 1));
      tick();
    end
    chk("dump_busy_drop", 32'(bus.dump_busy_o), 32'd0);
    chk("dump_valid_drop", 32'(bus.dump_valid_o), 32'd0);
    dump_start();
    chk("dump_restart_same_cycle", 32'(bus.dump_busy_o), 32'd1);
    wait_dump_idle(100, "dump_restart_timeout");
    tick();
    chk("dump_q_drained_1", 32'(dump_q.size()), 32'd0);

    // Random dump backpressure, ignored mid-dump start, concurrent reads.
    bus.dump_ready_i = 1'b0;
    dump_start();
    for (int it = 0; it < 400 && bus.dump_busy_o; it++) begin
      logic [3:0] a;
      bus.dump_ready_i = 1'($urandom_range(0, 1));
      bus.dump_start_i = (it == 4);
      a = 4'($urandom_range(0, 15));
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = a;
      rd_q.push_back(exp_rd(int'(a)));
      tick();
    end
    bus.dump_start_i = 1'b0;
    bus.req_valid_i  = 1'b0;
    if (bus.dump_busy_o) fail_now("dump_rand_timeout");
    tick();
    tick();
    chk("dump_q_drained_2", 32'(dump_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    // Reset mid-dump, then a clean restart from w0.
    bus.dump_ready_i = 1'b1;
    dump_start();
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.dump_busy_o), 32'd0);
    chk("rst_mid_valid", 32'(bus.dump_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    dump_start();
    chk("post_rst_first_word", bus.dump_data_o, 32'h43564136);
    wait_dump_idle(100, "post_rst_dump_timeout");
    tick();
    chk("dump_q_drained_3", 32'(dump_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
